i2s_transmitter: RTL and testbench

Serialises signed mono audio samples from the NCO into an I2S stream on i2s_bclk/i2s_ws/i2s_sd. It sits downstream of the NCO and the clk_div bit-clock enable, and drives the synth top-level I2S pins directly. The same sample is sent on the left and right slots. A one-deep holding register with a valid/ready handshake decouples the NCO from frame timing.

---
 rtl/synth_pkg.sv | 14 +
 rtl/i2s_transmitter.sv | 139 +++++++++++++
 tb/tb_i2s_transmitter.sv | 269 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/synth_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// synth_pkg : sample type and I2S framing constants shared across the synth
// Rev 1.0
// ----------------------------------------------------------------------------
package synth_pkg;

  localparam int DEFAULT_SAMPLE_WIDTH = 16;
  localparam int I2S_SLOT_WIDTH       = 16;

  typedef logic signed [DEFAULT_SAMPLE_WIDTH-1:0] sample_t;

endpackage
`default_nettype wire

// File: rtl/i2s_transmitter.sv
`default_nettype none
// ----------------------------------------------------------------------------
// i2s_transmitter : mono sample -> I2S serialiser, same sample on both slots,
//                   one-deep holding register with valid/ready handshake
// Rev 1.0
// ----------------------------------------------------------------------------
module i2s_transmitter
  import synth_pkg::*;
#(
  parameter int SAMPLE_WIDTH = DEFAULT_SAMPLE_WIDTH,
  parameter int SLOT_WIDTH   = I2S_SLOT_WIDTH
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           bit_clk_en,
  input  logic signed [SAMPLE_WIDTH-1:0] sample_data,
  input  logic                           sample_valid,
  output logic                           sample_ready,
  input  logic                           mute,
  output logic                           i2s_bclk,
  output logic                           i2s_ws,
  output logic                           i2s_sd,
  output logic                           frame_start,
  output logic                           underrun
);

  localparam int            KW        = $clog2(2*SLOT_WIDTH);
  localparam logic [KW-1:0] K_LAST    = KW'(2*SLOT_WIDTH-1);
  localparam logic [KW-1:0] K_SLOT    = KW'(SLOT_WIDTH);
  localparam logic [KW-1:0] K_WS_RISE = KW'(SLOT_WIDTH-1);

  logic                    bclk_q, bclk_d;
  logic [KW-1:0]           k_q, k_d;
  logic                    ws_q, ws_d;
  logic                    sd_q, sd_d;
  logic [SAMPLE_WIDTH-1:0] frame_q, frame_d;
  logic [SAMPLE_WIDTH-1:0] hold_q, hold_d;
  logic                    hold_full_q, hold_full_d;
  logic                    frame_start_q, frame_start_d;
  logic                    underrun_q, underrun_d;

  logic [KW-1:0]           w_k_next;
  logic [KW-1:0]           w_b;
  logic                    w_fall;
  logic                    w_load;
  logic                    w_accept;
  logic [SLOT_WIDTH-1:0]   w_slot_word;
  logic [SLOT_WIDTH-1:0]   w_shifted;

  always_comb begin
    bclk_d        = bclk_q;
    k_d           = k_q;
    ws_d          = ws_q;
    sd_d          = sd_q;
    frame_d       = frame_q;
    hold_d        = hold_q;
    hold_full_d   = hold_full_q;
    frame_start_d = 1'b0;
    underrun_d    = 1'b0;

    w_k_next = (k_q == K_LAST) ? '0 : k_q + KW'(1);
    w_fall   = bit_clk_en && bclk_q;
    w_load   = w_fall && (w_k_next == '0);
    w_accept = sample_valid && !hold_full_q;

    if (bit_clk_en) begin
      bclk_d = !bclk_q;
    end

    if (w_accept) begin
      hold_d      = sample_data;
      hold_full_d = 1'b1;
    end

    // Priority at frame load: mute, then held sample, then bypass, else silence.
    if (w_load) begin
      frame_start_d = 1'b1;
      if (mute) begin
        frame_d = '0;
        if (hold_full_q) begin
          hold_full_d = 1'b0;
        end
      end else if (hold_full_q) begin
        frame_d     = hold_q;
        hold_full_d = 1'b0;
      end else if (sample_valid) begin
        frame_d     = sample_data;
        hold_full_d = 1'b0;
      end else begin
        frame_d    = '0;
        underrun_d = 1'b1;
      end
    end

    w_b         = (w_k_next >= K_SLOT) ? (w_k_next - K_SLOT) : w_k_next;
    w_slot_word = SLOT_WIDTH'(frame_d) << (SLOT_WIDTH - SAMPLE_WIDTH);
    w_shifted   = w_slot_word << w_b;

    // ws leads the slot MSB by one bclk.
    if (w_fall) begin
      k_d  = w_k_next;
      ws_d = (w_k_next >= K_WS_RISE) && (w_k_next != K_LAST);
      sd_d = w_shifted[SLOT_WIDTH-1];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bclk_q        <= 1'b0;
      k_q           <= K_LAST;
      ws_q          <= 1'b0;
      sd_q          <= 1'b0;
      frame_q       <= '0;
      hold_q        <= '0;
      hold_full_q   <= 1'b0;
      frame_start_q <= 1'b0;
      underrun_q    <= 1'b0;
    end else begin
      bclk_q        <= bclk_d;
      k_q           <= k_d;
      ws_q          <= ws_d;
      sd_q          <= sd_d;
      frame_q       <= frame_d;
      hold_q        <= hold_d;
      hold_full_q   <= hold_full_d;
      frame_start_q <= frame_start_d;
      underrun_q    <= underrun_d;
    end
  end

  assign sample_ready = !hold_full_q;
  assign i2s_bclk     = bclk_q;
  assign i2s_ws       = ws_q;
  assign i2s_sd       = sd_q;
  assign frame_start  = frame_start_q;
  assign underrun     = underrun_q;

endmodule
`default_nettype wire

// File: tb/tb_i2s_transmitter.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_i2s_transmitter : directed bench with a frame-level reference model
// Rev 1.0
// ----------------------------------------------------------------------------
module tb_i2s_transmitter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        bit_clk_en = 1'b0;
  logic [15:0] sample_data = '0;
  logic        sample_valid = 1'b0;
  logic        mute = 1'b0;
  logic        sample_ready, i2s_bclk, i2s_ws, i2s_sd, frame_start, underrun;

  logic [15:0] data24 = '0;
  logic        valid24 = 1'b0;
  logic        ready24, bclk24, ws24, sd24, fs24, ur24;

  int tests = 0;
  int fails = 0;
  int en_seen = 0;

  i2s_transmitter #(.SAMPLE_WIDTH(16), .SLOT_WIDTH(16)) u_dut (
    .clk(clk), .rst(rst), .bit_clk_en(bit_clk_en),
    .sample_data(sample_data), .sample_valid(sample_valid), .sample_ready(sample_ready),
    .mute(mute), .i2s_bclk(i2s_bclk), .i2s_ws(i2s_ws), .i2s_sd(i2s_sd),
    .frame_start(frame_start), .underrun(underrun)
  );

  i2s_transmitter #(.SAMPLE_WIDTH(16), .SLOT_WIDTH(24)) u_dut24 (
    .clk(clk), .rst(rst), .bit_clk_en(bit_clk_en),
    .sample_data(data24), .sample_valid(valid24), .sample_ready(ready24),
    .mute(1'b0), .i2s_bclk(bclk24), .i2s_ws(ws24), .i2s_sd(sd24),
    .frame_start(fs24), .underrun(ur24)
  );

  initial forever #5 clk = ~clk;

  // bit_clk_en every 4 clks, phase restarted by reset
  initial begin
    int ph;
    ph = 0;
    forever begin
      @(negedge clk);
      #1;
      if (rst) begin
        ph = 0;
        bit_clk_en = 1'b0;
      end else begin
        bit_clk_en = (ph == 3);
        ph = (ph + 1) % 4;
      end
    end
  end

  // Reference model: k counts falling bclk edges modulo 32, frame chosen at k==0
  logic [15:0] hq[$];
  logic [15:0] m_frame;
  int          m_k;
  logic        m_bclk, m_fs, m_ur;

  always @(posedge clk) begin
    logic acc, fall, e_ws, e_sd, e_rdy;
    if (rst) begin
      m_bclk = 1'b0; m_k = 31; m_frame = '0; m_fs = 1'b0; m_ur = 1'b0;
      hq.delete();
      en_seen = 0;
    end else begin
      m_fs = 1'b0;
      m_ur = 1'b0;
      acc  = sample_valid && (hq.size() == 0);
      fall = bit_clk_en && m_bclk;
      if (bit_clk_en) begin
        m_bclk = !m_bclk;
        en_seen++;
      end
      if (fall) m_k = (m_k + 1) % 32;
      if (fall && m_k == 0) begin
        m_fs = 1'b1;
        if (mute) begin
          m_frame = '0;
          if (hq.size() != 0) void'(hq.pop_front());
          else if (acc) hq.push_back(sample_data);
        end else if (hq.size() != 0) begin
          m_frame = hq.pop_front();
        end else if (acc) begin
          m_frame = sample_data;
        end else begin
          m_frame = '0;
          m_ur = 1'b1;
        end
      end else if (acc) begin
        hq.push_back(sample_data);
      end
    end
    #1;
    e_ws  = ((m_k + 1) % 32) >= 16;
    e_sd  = m_frame[15 - (m_k % 16)];
    e_rdy = (hq.size() == 0);
    tests++;
    if ({i2s_bclk, i2s_ws, i2s_sd, sample_ready, frame_start, underrun} !==
        {m_bclk, e_ws, e_sd, e_rdy, m_fs, m_ur}) begin
      fails++;
      $display("FAIL model t=%0t k=%0d: bclk,ws,sd,ready,fs,ur got %b%b%b%b%b%b expected %b%b%b%b%b%b",
               $time, m_k, i2s_bclk, i2s_ws, i2s_sd, sample_ready, frame_start, underrun,
               m_bclk, e_ws, e_sd, e_rdy, m_fs, m_ur);
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; sample_valid = 1'b0; valid24 = 1'b0; mute = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic wait_en(input int n);
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk);
      #1;
      if (en_seen >= n) return;
    end
    chk("wait_en_timeout", 64'(en_seen), 64'(n));
  endtask

  task automatic push(input logic [15:0] d);
    logic r;
    sample_data  = d;
    sample_valid = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      r = sample_ready;
      @(negedge clk);
      if (r) begin
        sample_valid = 1'b0;
        return;
      end
    end
    sample_valid = 1'b0;
    chk("push_timeout", 64'(0), 64'(1));
  endtask

  initial begin
    logic [31:0] sd16, wsv16;
    logic [47:0] sdv24, wsv24;

    // 1: reset state, first frame underruns
    do_reset();
    #1;
    chk("rst_bclk", i2s_bclk, 0);
    chk("rst_ws", i2s_ws, 0);
    chk("rst_sd", i2s_sd, 0);
    chk("rst_ready", sample_ready, 1);
    chk("rst_fs", frame_start, 0);
    chk("rst_ur", underrun, 0);
    wait_en(1);
    chk("t1_bclk_rise", i2s_bclk, 1);
    wait_en(2);
    chk("t1_bclk_fall", i2s_bclk, 0);
    chk("t1_fs", frame_start, 1);
    chk("t1_ur", underrun, 1);
    chk("t1_sd", i2s_sd, 0);
    @(posedge clk); #1;
    chk("t1_fs_pulse", frame_start, 0);
    chk("t1_ur_pulse", underrun, 0);

    // 2 + 3: A5C3 on 16-bit slots, 8001 on 24-bit slots
    do_reset();
    sample_valid = 1'b1; sample_data = 16'hA5C3;
    valid24 = 1'b1; data24 = 16'h8001;
    @(negedge clk);
    sample_valid = 1'b0; valid24 = 1'b0;
    chk("t2_ready_full", sample_ready, 0);
    chk("t3_ready_full", ready24, 0);
    sd16 = '0; wsv16 = '0; sdv24 = '0; wsv24 = '0;
    for (int j = 0; j < 48; j++) begin
      wait_en(2 + 2*j);
      if (j == 0) begin
        chk("t2_ur", underrun, 0);
        chk("t3_fs", fs24, 1);
        chk("t3_ur", ur24, 0);
      end
      if (j < 32) begin
        sd16  = {sd16[30:0], i2s_sd};
        wsv16 = {wsv16[30:0], i2s_ws};
      end
      sdv24 = {sdv24[46:0], sd24};
      wsv24 = {wsv24[46:0], ws24};
    end
    chk("t2_sd_frame", sd16, 32'hA5C3_A5C3);
    chk("t2_ws_frame", wsv16, 32'h0001_FFFE);
    chk("t3_sd_frame", sdv24, 48'h8001_0080_0100);
    chk("t3_ws_frame", wsv24, 48'h0000_01FF_FFFE);

    // 4: back-to-back pushes
    do_reset();
    push(16'h1234);
    chk("t4_ready_held", sample_ready, 0);
    push(16'hC3A5);
    chk("t4_accept_after_load", 64'(en_seen), 64'(2));
    chk("t4_ready_second", sample_ready, 0);
    wait_en(66);
    chk("t4_fs2", frame_start, 1);
    chk("t4_sd2_msb", i2s_sd, 1);
    chk("t4_ur2", underrun, 0);

    // 5: mute with holding full
    do_reset();
    mute = 1'b1;
    push(16'hFFFF);
    wait_en(2);
    chk("t5_fs", frame_start, 1);
    chk("t5_ur", underrun, 0);
    chk("t5_sd", i2s_sd, 0);
    chk("t5_ready", sample_ready, 1);
    mute = 1'b0;
    wait_en(66);
    chk("t5_next_ur", underrun, 1);

    // 6: bypass on the load clk
    do_reset();
    wait_en(1);
    repeat (3) @(posedge clk);
    @(negedge clk);
    sample_valid = 1'b1; sample_data = 16'h7FFF;
    @(posedge clk); #1;
    sample_valid = 1'b0;
    chk("t6_fs", frame_start, 1);
    chk("t6_ur", underrun, 0);
    chk("t6_sd_msb", i2s_sd, 0);
    chk("t6_ready", sample_ready, 1);
    wait_en(4);
    chk("t6_sd_bit14", i2s_sd, 1);

    // 7: reset mid-frame at k=10
    do_reset();
    push(16'hA5C3);
    wait_en(22);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("t7_bclk", i2s_bclk, 0);
    chk("t7_ws", i2s_ws, 0);
    chk("t7_sd", i2s_sd, 0);
    chk("t7_ready", sample_ready, 1);
    chk("t7_fs", frame_start, 0);
    chk("t7_ur", underrun, 0);
    @(negedge clk);
    rst = 1'b0;
    wait_en(2);
    chk("t7_restart_fs", frame_start, 1);
    chk("t7_restart_ur", underrun, 1);
    chk("t7_restart_sd", i2s_sd, 0);
    wait_en(4);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
